// File: rtl/shift_seq_pkg.sv
// Shared encodings for the shift sequencer: shift modes and controller states.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_ASR = 2'b01,
        MODE_LSL = 2'b10,
        MODE_ROR = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_stage.sv
// One-position shift/rotate stage; purely combinational.
module shift_stage
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out
);

    always_comb begin
        out = in;
        case (mode)
            MODE_LSR: out = {1'b0, in[WIDTH-1:1]};
            MODE_ASR: out = {in[WIDTH-1], in[WIDTH-1:1]};
            MODE_LSL: out = {in[WIDTH-2:0], 1'b0};
            MODE_ROR: out = {in[0], in[WIDTH-1:1]};
            default:  out = in;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate controller: iterates a single-step stage amount times
// on the data_out register, then pulses done for one cycle.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amount,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    // Handshake: a request transfers on the rising edge where start=1 and ready=1;
    // start in any other cycle is dropped. done is a single-cycle result strobe
    // with no back-pressure, and data_out holds until the next accepted request.

    state_e            state;
    shift_mode_e       mode_q;
    logic [AMT_W-1:0]  count;
    logic [WIDTH-1:0]  stage_out;

    shift_stage #(.WIDTH(WIDTH)) u_stage (
        .in   (data_out),
        .mode (mode_q),
        .out  (stage_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_LSR;
            count    <= '0;
            data_out <= '0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mode_q   <= shift_mode_e'(mode);
                        count    <= amount;
                        data_out <= data_in;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                        // A zero amount skips the loop entirely; the operand is the result.
                        if (amount == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_out <= stage_out;
                    count    <= count - AMT_W'(1);
                    if (count == AMT_W'(1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomized checks of shift_sequencer against a closed-form shift model.
module tb_shift_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic [2:0] amount;
    logic [3:0] data_in;
    logic       ready;
    logic       busy;
    logic       done;
    logic [3:0] data_out;

    int total = 0;
    int bad   = 0;

    shift_sequencer #(.WIDTH(4), .AMT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .amount   (amount),
        .data_in  (data_in),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Whole-shift result computed directly from the amount, not step by step.
    function automatic logic [3:0] ref_model(input logic [1:0] m, input logic [2:0] a,
                                             input logic [3:0] d);
        logic [3:0] r;
        logic [7:0] dd;
        int k;
        case (m)
            2'b00:   r = d >> a;
            2'b01:   r = 4'($signed(d) >>> a);
            2'b10:   r = 4'(d << a);
            default: begin
                k  = int'(a) % 4;
                dd = {d, d} >> k;
                r  = dd[3:0];
            end
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] m, input logic [2:0] a, input logic [3:0] d,
                          input bit noise, input string tag);
        int lat;
        logic [3:0] exp;
        exp = ref_model(m, a, d);
        @(negedge clk);
        check({tag, " ready_before"}, 8'(ready), 8'd1);
        start = 1'b1; mode = m; amount = a; data_in = d;
        @(posedge clk); #1;
        lat   = 1;
        start = 1'b0;
        check({tag, " busy_after_accept"}, {6'd0, busy, ready}, 8'b10);
        while (done !== 1'b1 && lat < 40) begin
            if (noise) begin
                start   = 1'b1;
                mode    = 2'($urandom);
                amount  = 3'($urandom);
                data_in = 4'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 8'(lat), 8'(int'(a) + 1));
        check({tag, " result"}, 8'(data_out), 8'(exp));
        if (noise) begin
            start   = 1'b1;
            data_in = ~exp;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " after_done"}, {3'd0, done, ready, busy, 2'd0}, {3'd0, 1'b0, 1'b1, 1'b0, 2'd0});
        check({tag, " data_hold"}, 8'(data_out), 8'(exp));
    endtask

    initial begin
        int done_seen;
        rst = 1'b1; start = 1'b0; mode = 2'b00; amount = 3'd0; data_in = 4'd0;
        #12;
        check("reset_state", {done, ready, busy, 1'b0, data_out}, {1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
        @(negedge clk);
        rst = 1'b0;

        run_op(2'b01, 3'd1, 4'b1010, 1'b0, "asr_1010_by1");
        run_op(2'b00, 3'd1, 4'b1010, 1'b0, "lsr_1010_by1");
        run_op(2'b10, 3'd2, 4'b0011, 1'b0, "lsl_0011_by2");
        for (int mi = 0; mi < 4; mi++)
            run_op(2'(mi), 3'd0, 4'b0110, 1'b0, "amount0");
        run_op(2'b01, 3'd7, 4'b1000, 1'b0, "asr_1000_by7");
        run_op(2'b11, 3'd5, 4'b1001, 1'b0, "ror_1001_by5");
        run_op(2'b00, 3'd6, 4'b1111, 1'b0, "lsr_1111_by6");
        run_op(2'b11, 3'd3, 4'b0001, 1'b1, "busy_start_ignored");
        run_op(2'b10, 3'd1, 4'b0101, 1'b0, "next_after_ignored");

        // Asynchronous reset in the middle of a shift.
        @(negedge clk);
        start = 1'b1; mode = 2'b11; amount = 3'd6; data_in = 4'b1011;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("midshift_reset", {done, ready, busy, 1'b0, data_out}, {1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (done === 1'b1) done_seen++;
        end
        check("no_done_after_reset", 8'(done_seen), 8'd0);
        check("idle_after_reset", {6'd0, ready, busy}, 8'b10);

        for (int i = 0; i < 40; i++)
            run_op(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                   4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), "random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
